// File: rtl/convertidor_ascii_a_dec.sv
// Converts a stream of ASCII digits ended by TERMINADOR into three BCD digits.
// Optional malformed-input detection is compiled in with the ASCII_DEC_ERROR_EN macro.
module convertidor_ascii_a_dec #(
   parameter logic [7:0] TERMINADOR = 8'h0D
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] datoAscii,
   input  logic       datoValido,
   output logic       listo,
   output logic [3:0] unidades,
   output logic [3:0] decenas,
   output logic [3:0] centenas,
   output logic       numeroValido,
   output logic       error
);

   typedef enum logic [1:0] {
      ESPERA   = 2'd0,
      ACUMULA  = 2'd1,
      ENTREGA  = 2'd2,
      DESCARTA = 2'd3
   } estado_t;

   estado_t    r_estado, w_estado_sig;
   logic [3:0] r_uni, r_dec, r_cen;
   logic [3:0] w_uni_sig, w_dec_sig, w_cen_sig;
   logic [1:0] r_cuenta, w_cuenta_sig;
   logic [3:0] r_sal_uni, r_sal_dec, r_sal_cen;
   logic [3:0] w_sal_uni_sig, w_sal_dec_sig, w_sal_cen_sig;
   logic       r_numero_valido, w_numero_valido_sig;

   logic       w_consumo;
   logic       w_es_digito;
   logic       w_es_term;
   logic [3:0] w_digito;

   assign listo       = (r_estado != ENTREGA);
   assign w_consumo   = datoValido && listo;
   assign w_es_digito = (datoAscii >= 8'h30) && (datoAscii <= 8'h39);
   assign w_es_term   = (datoAscii == TERMINADOR);
   // For 8'h30..8'h39 the low nibble already equals datoAscii - 8'h30.
   assign w_digito    = datoAscii[3:0];

`ifdef ASCII_DEC_ERROR_EN
   logic r_error, w_error_sig;
`endif

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned (no latch).
      w_estado_sig        = r_estado;
      w_uni_sig           = r_uni;
      w_dec_sig           = r_dec;
      w_cen_sig           = r_cen;
      w_cuenta_sig        = r_cuenta;
      w_sal_uni_sig       = r_sal_uni;
      w_sal_dec_sig       = r_sal_dec;
      w_sal_cen_sig       = r_sal_cen;
      w_numero_valido_sig = 1'b0;
`ifdef ASCII_DEC_ERROR_EN
      w_error_sig         = 1'b0;
`endif

      case (r_estado)
         ESPERA: begin
            if (w_consumo) begin
               if (w_es_digito) begin
                  w_uni_sig    = w_digito;
                  w_dec_sig    = 4'd0;
                  w_cen_sig    = 4'd0;
                  w_cuenta_sig = 2'd1;
                  w_estado_sig = ACUMULA;
               end
`ifdef ASCII_DEC_ERROR_EN
               else if (!w_es_term && (datoAscii != 8'h00)) begin
                  w_error_sig  = 1'b1;
                  w_estado_sig = DESCARTA;
               end
`endif
            end
         end

         ACUMULA: begin
            if (w_consumo) begin
`ifdef ASCII_DEC_ERROR_EN
               if (w_es_digito && (r_cuenta == 2'd3)) begin
                  w_error_sig  = 1'b1;
                  w_estado_sig = DESCARTA;
               end else
`endif
               if (w_es_digito) begin
                  w_cen_sig = r_dec;
                  w_dec_sig = r_uni;
                  w_uni_sig = w_digito;
                  if (r_cuenta != 2'd3) w_cuenta_sig = r_cuenta + 2'd1;
               end else if (w_es_term) begin
                  // Outputs and the pulse are registered on the terminator edge, so they
                  // are visible during the single ENTREGA cycle while listo is low.
                  w_sal_uni_sig       = r_uni;
                  w_sal_dec_sig       = r_dec;
                  w_sal_cen_sig       = r_cen;
                  w_numero_valido_sig = 1'b1;
                  w_estado_sig        = ENTREGA;
               end
`ifdef ASCII_DEC_ERROR_EN
               else begin
                  w_error_sig  = 1'b1;
                  w_estado_sig = DESCARTA;
               end
`endif
            end
         end

         ENTREGA: begin
            w_uni_sig    = 4'd0;
            w_dec_sig    = 4'd0;
            w_cen_sig    = 4'd0;
            w_cuenta_sig = 2'd0;
            w_estado_sig = ESPERA;
         end

         DESCARTA: begin
            if (w_consumo && w_es_term) begin
               w_uni_sig    = 4'd0;
               w_dec_sig    = 4'd0;
               w_cen_sig    = 4'd0;
               w_cuenta_sig = 2'd0;
               w_estado_sig = ESPERA;
            end
         end

         default: w_estado_sig = ESPERA;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_estado        <= ESPERA;
         r_uni           <= 4'd0;
         r_dec           <= 4'd0;
         r_cen           <= 4'd0;
         r_cuenta        <= 2'd0;
         r_sal_uni       <= 4'd0;
         r_sal_dec       <= 4'd0;
         r_sal_cen       <= 4'd0;
         r_numero_valido <= 1'b0;
      end else begin
         r_estado        <= w_estado_sig;
         r_uni           <= w_uni_sig;
         r_dec           <= w_dec_sig;
         r_cen           <= w_cen_sig;
         r_cuenta        <= w_cuenta_sig;
         r_sal_uni       <= w_sal_uni_sig;
         r_sal_dec       <= w_sal_dec_sig;
         r_sal_cen       <= w_sal_cen_sig;
         r_numero_valido <= w_numero_valido_sig;
      end
   end

`ifdef ASCII_DEC_ERROR_EN
   always_ff @(posedge clk) begin
      if (!rst_n) r_error <= 1'b0;
      else        r_error <= w_error_sig;
   end
   assign error = r_error;
`else
   assign error = 1'b0;
`endif

   assign unidades     = r_sal_uni;
   assign decenas      = r_sal_dec;
   assign centenas     = r_sal_cen;
   assign numeroValido = r_numero_valido;

endmodule

// File: doc/convertidor_ascii_a_dec.md
CONVERTIDOR_ASCII_A_DEC -- requirements
Module: convertidor_ascii_a_dec

Interface
REQ-001 Parameter TERMINADOR, default 8'h0D, ASCII byte that ends a number.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 datoAscii  input  8  incoming ASCII byte.
REQ-005 datoValido  input  1  datoAscii valid this cycle.
REQ-006 listo  output  1  block can accept a byte this cycle.
REQ-007 unidades  output  4  BCD units of the last delivered number.
REQ-008 decenas  output  4  BCD tens of the last delivered number.
REQ-009 centenas  output  4  BCD hundreds of the last delivered number.
REQ-010 numeroValido  output  1  one-cycle pulse: new number on unidades/decenas/centenas.
REQ-011 error  output  1  one-cycle pulse: malformed input detected.

Function
REQ-012 A byte SHALL be consumed only on a rising edge where datoValido=1 and listo=1; all other bytes are ignored.
REQ-013 The FSM SHALL have the states ESPERA (no digits), ACUMULA (1-3 digits held), ENTREGA (delivery) and DESCARTA (discard until terminator).
REQ-014 A digit byte (8'h30-8'h39) SHALL be converted to datoAscii-8'h30 and shifted into an internal 3-digit register: new digit to units, units to tens, tens to hundreds; digit count increments.
REQ-015 ESPERA: a digit goes to ACUMULA with count=1 and internal tens/hundreds=0; byte 8'h00 (blank leading position) and TERMINADOR SHALL be ignored with no pulse.
REQ-016 ACUMULA: a digit with count<3 is accepted and the state stays ACUMULA; TERMINADOR goes to ENTREGA.
REQ-017 ENTREGA SHALL last exactly one cycle: outputs load the internal register, numeroValido=1, listo=0, internal register and count clear, next state ESPERA.
REQ-018 numeroValido SHALL rise on the first edge after the terminator handshake (latency 1 cycle); unidades/decenas/centenas SHALL change only on that edge and hold until the next delivery.
REQ-019 listo SHALL be 1 in ESPERA, ACUMULA and DESCARTA and 0 in ENTREGA.
REQ-020 Leading zeros are legal: "0","0","7",TERMINADOR delivers centenas=0, decenas=0, unidades=7.
REQ-021 Byte handling SHALL be defined by the Configuration section for: a non-digit non-terminator in ACUMULA, a non-digit other than 8'h00 in ESPERA, and a fourth digit.
REQ-022 DESCARTA: every byte except TERMINADOR SHALL be consumed and dropped with no further error pulse; TERMINADOR goes to ESPERA with no numeroValido.

Reset
REQ-023 When rst_n=0 at a rising edge: state=ESPERA, count=0, internal register=0, unidades=decenas=centenas=0, numeroValido=0, error=0.
REQ-024 Reset mid-number SHALL discard partial digits with no pulse; listo=1 on the first cycle after rst_n returns to 1.
REQ-025 rst_n=0 SHALL take priority over a simultaneous byte handshake.

Configuration
REQ-026 With macro ASCII_DEC_ERROR_EN defined: a bad byte or a fourth digit SHALL pulse error for one cycle on the consuming edge and go to DESCARTA.
REQ-027 Without ASCII_DEC_ERROR_EN: bad bytes SHALL be ignored; a fourth digit SHALL shift in and drop the oldest digit, so the last three digits are kept; error SHALL be tied to 0 and DESCARTA is unreachable.

Verification
REQ-028 Reset; send 8'h31,8'h32,8'h33,8'h0D -> one cycle later numeroValido=1, centenas=1, decenas=2, unidades=3, listo=0 for that one cycle.
REQ-029 Send 8'h00,8'h00,8'h35,8'h0D -> numeroValido pulse, outputs 0,0,5; a lone 8'h0D in ESPERA -> no pulse, outputs unchanged.
REQ-030 Feature on: send 8'h31,8'h41 -> error pulse on the 8'h41 edge; then 8'h32,8'h0D -> no numeroValido; then 8'h39,8'h0D -> outputs 0,0,9.
REQ-031 Send 8'h31,8'h32,8'h33,8'h34,8'h0D -> feature on: error pulse, no delivery; feature off: outputs 2,3,4, error stays 0.
REQ-032 Send 8'h37,8'h38, assert rst_n=0 for one cycle, then send 8'h0D -> no numeroValido, outputs 0,0,0.
REQ-033 Hold datoValido=1 across the ENTREGA cycle with the next digit 8'h36 -> the byte is not consumed until listo=1; the next number's units=6.
